riscv_imem_arb: RTL and testbench
=================================

Name: riscv_imem_arb

Overview:
- Two-requester arbiter and sequencer in front of the single-ported synchronous instruction memory array.
- Requester 1 is the core fetch unit, which is read-only. Requester 2 is the program loader / debug port, which can read and write with byte enables.
- The block issues at most one memory access per cycle, returns read data one cycle later, and supports a loader lock for exclusive burst programming.

Parameters:
- XLEN, 32, data word width in bits.
- AW, 10, memory word-address width. Depth is 2**AW words.
- BW, XLEN/8, byte-enable width.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_f_req  input  1  fetch read request.
- i_f_addr  input  AW  fetch word address.
- o_f_gnt  output  1  fetch request accepted this cycle.
- o_f_rvalid  output  1  fetch read data valid.
- o_f_rdata  output  XLEN  fetch read data.
- i_l_req  input  1  loader request.
- i_l_we  input  1  loader write (1) or read (0).
- i_l_lock  input  1  loader requests exclusive ownership.
- i_l_addr  input  AW  loader word address.
- i_l_wdata  input  XLEN  loader write data.
- i_l_be  input  BW  loader byte enables.
- o_l_gnt  output  1  loader request accepted this cycle.
- o_l_rvalid  output  1  loader read data valid.
- o_l_rdata  output  XLEN  loader read data.
- o_lock  output  1  arbiter is in the LOCK state.
- o_l_wcnt  output  AW+1  count of loader writes since the last LOCK entry.
- o_mem_cs  output  1  memory access strobe.
- o_mem_we  output  1  memory write.
- o_mem_be  output  BW  memory byte enables.
- o_mem_addr  output  AW  memory word address.
- o_mem_wdata  output  XLEN  memory write data.
- i_mem_rdata  input  XLEN  memory read data, valid the cycle after a read is issued.

Behaviour:
- Reset: single clock i_clk; i_rstn is asynchronous and active-low. While i_rstn=0:
  - state = ARB, last_gnt = LOADER (so fetch wins the first contention).
  - rsp_valid = 0; o_f_rvalid = o_l_rvalid = 0; o_lock = 0; o_l_wcnt = 0.
  - o_f_gnt = o_l_gnt = 0; o_mem_cs = 0.
- Grant is combinational, in the same cycle as the request. Request fields are sampled only in the grant cycle. A requester holds its request and fields until granted; the arbiter does not queue requests.
- ARB state:
  - Only one requester active: that requester is granted.
  - Both active: the requester not granted last is granted (round-robin).
  - last_gnt updates on every grant.
- LOCK state:
  - o_f_gnt = 0 unconditionally.
  - Loader is granted whenever i_l_req = 1.
- Transitions:
  - ARB -> LOCK: on a loader grant with i_l_lock = 1. o_l_wcnt clears to 0 on entry, then counts that granted access if it is a write.
  - LOCK -> ARB: on any cycle with i_l_lock = 0, whether or not a request is present. That cycle is still arbitrated as LOCK, so fetch is not granted in the exit cycle.
  - o_lock = (state == LOCK), registered.
- Memory drive, combinational from the granted request:
  - o_mem_cs = o_f_gnt | o_l_gnt; o_mem_addr = granted address.
  - o_mem_we = o_l_gnt & i_l_we.
  - o_mem_be: fetch grant gives all ones; loader grant gives i_l_be.
  - o_mem_wdata = i_l_wdata.
  - With no grant: o_mem_cs = 0, o_mem_we = 0, o_mem_be = 0; address and wdata are don't-care, but bench compares them as 0.
- Read response:
  - A granted read sets rsp_valid = 1 and rsp_owner next cycle. Writes produce no response.
  - o_f_rvalid = rsp_valid & owner==FETCH; o_l_rvalid = rsp_valid & owner==LOADER. Both are registered, so latency is exactly 1 cycle after grant.
  - o_x_rdata = i_mem_rdata when the corresponding rvalid = 1, else 0.
  - Responses cannot be back-pressured. Back-to-back reads give back-to-back responses.
- o_l_wcnt: increments on each granted loader write and saturates at 2**AW. It clears only on reset or on LOCK entry, and holds its value after LOCK exit.
- A write with i_l_be = 0 is still granted and counted; the memory performs no byte updates.
- Reset asserted mid-operation: the pending response is dropped (no rvalid), and state returns to ARB immediately.

Test Plan:
- Reset:
  - Stimulus: assert i_rstn=0 while i_f_req=i_l_req=1.
  - Response: all gnt/rvalid/cs = 0, o_lock = 0, o_l_wcnt = 0.
- Round-robin:
  - Stimulus: i_rstn=1, both requests held 4 cycles.
  - Response: grants F, L, F, L. rvalid follows each read by 1 cycle with rdata = memory content at 0x004 / 0x010.
- Single fetch stream:
  - Stimulus: fetch addresses 0,1,2,3 back-to-back.
  - Response: gnt on every cycle, o_f_rvalid on cycles 1-4, rdata equal to the preloaded words.
- Lock burst:
  - Stimulus: loader lock=1 writes 0xDEADBEEF, 0x12345678 to addresses 8, 9 with be=4'hF, with fetch requesting throughout.
  - Response: o_f_gnt = 0 during the burst, o_lock = 1, o_l_wcnt = 2.
  - Stimulus: drop lock.
  - Response: fetch is granted the cycle after the exit cycle. A fetch of address 8 returns 0xDEADBEEF.
- Byte-enable write:
  - Stimulus: address 8 holds 0xDEADBEEF; loader writes be=4'b0011, wdata=0x0000AAAA; loader then reads address 8.
  - Response: read returns 0xDEADAAAA on o_l_rvalid; o_f_rvalid stays 0.
- Reset mid-read:
  - Stimulus: assert i_rstn=0 in the cycle after a fetch grant.
  - Response: no o_f_rvalid. After release, state = ARB and fetch wins the first contention.

Source files
------------

// File: rtl/riscv_imem_arb.sv
// Instruction-memory arbiter: core fetch (read-only) vs loader/debug (R/W with
// byte enables) sharing one single-ported synchronous memory. Round-robin in
// ARB, loader-exclusive in LOCK, one access per cycle, read data 1 cycle later.
module riscv_imem_arb #(
  parameter int XLEN = 32,
  parameter int AW   = 10,
  parameter int BW   = XLEN/8
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_f_req,
  input  logic [AW-1:0]   i_f_addr,
  output logic            o_f_gnt,
  output logic            o_f_rvalid,
  output logic [XLEN-1:0] o_f_rdata,
  input  logic            i_l_req,
  input  logic            i_l_we,
  input  logic            i_l_lock,
  input  logic [AW-1:0]   i_l_addr,
  input  logic [XLEN-1:0] i_l_wdata,
  input  logic [BW-1:0]   i_l_be,
  output logic            o_l_gnt,
  output logic            o_l_rvalid,
  output logic [XLEN-1:0] o_l_rdata,
  output logic            o_lock,
  output logic [AW:0]     o_l_wcnt,
  output logic            o_mem_cs,
  output logic            o_mem_we,
  output logic [BW-1:0]   o_mem_be,
  output logic [AW-1:0]   o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic [XLEN-1:0] i_mem_rdata
);

  typedef enum logic { ARB, LOCK } state_e;
  typedef enum logic { OWN_F, OWN_L } owner_e;

  typedef struct packed {
    logic            cs;
    logic            we;
    logic [BW-1:0]   be;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

  // Write counter saturates at exactly 2**AW, hence the extra bit.
  localparam logic [AW:0] WCNT_MAX = {1'b1, {AW{1'b0}}};

  state_e      state_q, state_d;
  owner_e      last_q, rsp_owner_q;
  logic        rsp_valid_q;
  logic [AW:0] wcnt_q, wcnt_d;
  logic        f_gnt, l_gnt;
  mem_req_t    mreq;

  // Grant decision and next state; grants are forced low while in reset.
  always_comb begin
    f_gnt   = 1'b0;
    l_gnt   = 1'b0;
    state_d = state_q;
    if (i_rstn) begin
      case (state_q)
        ARB: begin
          if (i_f_req && i_l_req) begin
            f_gnt = (last_q == OWN_L);
            l_gnt = (last_q == OWN_F);
          end else begin
            f_gnt = i_f_req;
            l_gnt = i_l_req;
          end
          if (l_gnt && i_l_lock) state_d = LOCK;
        end
        LOCK: begin
          // Exit cycle is still arbitrated as LOCK: fetch stays blocked.
          l_gnt = i_l_req;
          if (!i_l_lock) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  // Loader write count: cleared on LOCK entry, then the entry access counts too.
  always_comb begin
    wcnt_d = wcnt_q;
    if (state_q == ARB && state_d == LOCK) wcnt_d = '0;
    if (l_gnt && i_l_we && wcnt_d != WCNT_MAX) wcnt_d = wcnt_d + (AW+1)'(1);
  end

  // Memory drive from the granted request; idle drives all zeros.
  always_comb begin
    mreq = '0;
    if (f_gnt) begin
      mreq.cs    = 1'b1;
      mreq.be    = '1;
      mreq.addr  = i_f_addr;
      mreq.wdata = i_l_wdata;
    end else if (l_gnt) begin
      mreq.cs    = 1'b1;
      mreq.we    = i_l_we;
      mreq.be    = i_l_be;
      mreq.addr  = i_l_addr;
      mreq.wdata = i_l_wdata;
    end
  end

  // State, round-robin pointer, response tracking and write counter.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ARB;
      last_q      <= OWN_L;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= OWN_F;
      wcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rsp_valid_q <= f_gnt | (l_gnt & ~i_l_we);
      if (f_gnt) begin
        last_q      <= OWN_F;
        rsp_owner_q <= OWN_F;
      end else if (l_gnt) begin
        last_q      <= OWN_L;
        rsp_owner_q <= OWN_L;
      end
    end
  end

  assign o_f_gnt     = f_gnt;
  assign o_l_gnt     = l_gnt;
  assign o_mem_cs    = mreq.cs;
  assign o_mem_we    = mreq.we;
  assign o_mem_be    = mreq.be;
  assign o_mem_addr  = mreq.addr;
  assign o_mem_wdata = mreq.wdata;

  assign o_lock      = (state_q == LOCK);
  assign o_l_wcnt    = wcnt_q;
  assign o_f_rvalid  = rsp_valid_q && (rsp_owner_q == OWN_F);
  assign o_l_rvalid  = rsp_valid_q && (rsp_owner_q == OWN_L);
  assign o_f_rdata   = o_f_rvalid ? i_mem_rdata : '0;
  assign o_l_rdata   = o_l_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_riscv_imem_arb.sv
// Bench for riscv_imem_arb: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model with its own memory.
module tb_riscv_imem_arb;
  localparam int AW   = 5;
  localparam int XLEN = 32;
  localparam int BW   = 4;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            rstn;
  logic            f_req, f_gnt, f_rvalid;
  logic [AW-1:0]   f_addr;
  logic [XLEN-1:0] f_rdata;
  logic            l_req, l_we, l_lock, l_gnt, l_rvalid;
  logic [AW-1:0]   l_addr;
  logic [XLEN-1:0] l_wdata, l_rdata;
  logic [BW-1:0]   l_be;
  logic            lock;
  logic [AW:0]     wcnt;
  logic            mem_cs, mem_we;
  logic [BW-1:0]   mem_be;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata, mem_rdata;

  riscv_imem_arb #(.XLEN(XLEN), .AW(AW), .BW(BW)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt),
    .o_f_rvalid(f_rvalid), .o_f_rdata(f_rdata),
    .i_l_req(l_req), .i_l_we(l_we), .i_l_lock(l_lock), .i_l_addr(l_addr),
    .i_l_wdata(l_wdata), .i_l_be(l_be), .o_l_gnt(l_gnt),
    .o_l_rvalid(l_rvalid), .o_l_rdata(l_rdata),
    .o_lock(lock), .o_l_wcnt(wcnt),
    .o_mem_cs(mem_cs), .o_mem_we(mem_we), .o_mem_be(mem_be),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Memory array seen by the DUT: synchronous, byte-writable, 1-cycle read.
  logic [31:0] env_mem [DEPTH];
  bit preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) env_mem[i] <= init_word(i);
    end else if (mem_cs) begin
      if (mem_we) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) env_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= env_mem[mem_addr];
      end
    end
  end

  // Reference model state (transaction level).
  bit          m_lock, m_last_l, m_rsp_v, m_rsp_l;
  logic [31:0] m_rsp_data;
  int          m_wcnt;
  logic [31:0] ref_mem [DEPTH];
  bit          e_fg, e_lg;

  // DUT outputs sampled at the last compare point, used by literal pins.
  bit          s_fg, s_lg, s_fv, s_lv, s_lock;
  logic [31:0] s_frd, s_lrd;
  int          s_wcnt;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: compare at negedge, advance model, release at posedge+1.
  task automatic step();
    bit fg, lg, cs;
    logic [3:0]  be;
    logic [AW-1:0] addr;
    logic [31:0] wd, erf, erl;
    @(negedge clk);
    if (!rstn) begin
      m_lock = 0; m_last_l = 1; m_rsp_v = 0; m_rsp_l = 0; m_wcnt = 0;
    end
    fg = 0; lg = 0;
    if (rstn) begin
      if (m_lock) lg = l_req;
      else if (f_req && l_req) begin fg = m_last_l; lg = !m_last_l; end
      else begin fg = f_req; lg = l_req; end
    end
    cs   = fg | lg;
    be   = fg ? 4'hF : (lg ? l_be : 4'h0);
    addr = fg ? f_addr : (lg ? l_addr : '0);
    wd   = cs ? l_wdata : 32'h0;
    erf  = (m_rsp_v && !m_rsp_l) ? m_rsp_data : 32'h0;
    erl  = (m_rsp_v &&  m_rsp_l) ? m_rsp_data : 32'h0;

    check("f_gnt",     32'(f_gnt),     32'(fg));
    check("l_gnt",     32'(l_gnt),     32'(lg));
    check("mem_cs",    32'(mem_cs),    32'(cs));
    check("mem_we",    32'(mem_we),    32'(lg && l_we));
    check("mem_be",    32'(mem_be),    32'(be));
    check("mem_addr",  32'(mem_addr),  32'(addr));
    check("mem_wdata", mem_wdata,      wd);
    check("f_rvalid",  32'(f_rvalid),  32'(m_rsp_v && !m_rsp_l));
    check("l_rvalid",  32'(l_rvalid),  32'(m_rsp_v && m_rsp_l));
    check("f_rdata",   f_rdata,        erf);
    check("l_rdata",   l_rdata,        erl);
    check("lock",      32'(lock),      32'(m_lock));
    check("wcnt",      32'(wcnt),      32'(m_wcnt));

    s_fg = f_gnt; s_lg = l_gnt; s_fv = f_rvalid; s_lv = l_rvalid;
    s_lock = lock; s_frd = f_rdata; s_lrd = l_rdata; s_wcnt = int'(wcnt);

    if (rstn) begin
      m_rsp_v    = fg | (lg & !l_we);
      m_rsp_l    = lg;
      m_rsp_data = ref_mem[addr];
      if (lg && l_we)
        for (int b = 0; b < BW; b++)
          if (l_be[b]) ref_mem[l_addr][8*b +: 8] = l_wdata[8*b +: 8];
      if (!m_lock && lg && l_lock) m_wcnt = 0;
      if (lg && l_we && m_wcnt < DEPTH) m_wcnt++;
      m_lock = m_lock ? l_lock : (lg && l_lock);
      if (cs) m_last_l = lg;
    end
    e_fg = fg; e_lg = lg;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit burst = 0;
    rstn = 0; f_req = 0; f_addr = '0; l_req = 0; l_we = 0; l_lock = 0;
    l_addr = '0; l_wdata = '0; l_be = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    step();
    preload = 0;

    // Reset with both requesting: everything quiet.
    f_req = 1; l_req = 1;
    step();
    check("rst_fgnt", 32'(s_fg), 32'd0);
    check("rst_lgnt", 32'(s_lg), 32'd0);
    check("rst_lock", 32'(s_lock), 32'd0);
    check("rst_wcnt", 32'(s_wcnt), 32'd0);

    // Round-robin: F, L, F, L.
    rstn = 1; f_addr = 5'd4; l_we = 0; l_addr = 5'd16;
    step(); check("rr_g0", {30'd0, s_fg, s_lg}, 32'b10);
    step(); check("rr_g1", {30'd0, s_fg, s_lg}, 32'b01);
            check("rr_fd", s_frd, 32'hC0DE0004);
    step(); check("rr_g2", {30'd0, s_fg, s_lg}, 32'b10);
            check("rr_ld", s_lrd, 32'hC0DE0010);
    step(); check("rr_g3", {30'd0, s_fg, s_lg}, 32'b01);
    f_req = 0; l_req = 0;
    step(); check("rr_lv", 32'(s_lv), 32'd1);

    // Back-to-back fetch stream.
    for (int k = 0; k < 4; k++) begin
      f_req = 1; f_addr = AW'(k);
      step();
      check("fs_gnt", 32'(s_fg), 32'd1);
      if (k > 0) check("fs_rd", s_frd, 32'hC0DE0000 + 32'(k - 1));
    end
    f_req = 0;
    step(); check("fs_rd3", s_frd, 32'hC0DE0003);

    // Locked burst with fetch pending throughout.
    f_req = 1; f_addr = 5'd8;
    l_req = 1; l_we = 1; l_lock = 1; l_addr = 5'd8; l_wdata = 32'hDEADBEEF; l_be = 4'hF;
    step(); check("lk_g0", {30'd0, s_fg, s_lg}, 32'b01);
    l_addr = 5'd9; l_wdata = 32'h12345678;
    step(); check("lk_g1", {30'd0, s_fg, s_lg}, 32'b01);
            check("lk_on", 32'(s_lock), 32'd1);
    l_req = 0;
    step(); check("lk_fg", 32'(s_fg), 32'd0);
            check("lk_wcnt", 32'(s_wcnt), 32'd2);
    l_lock = 0;
    step(); check("lk_exit_fg", 32'(s_fg), 32'd0);
            check("lk_exit_lock", 32'(s_lock), 32'd1);
    step(); check("lk_after_fg", 32'(s_fg), 32'd1);
            check("lk_after_lock", 32'(s_lock), 32'd0);
    f_req = 0;
    step(); check("lk_rd8", s_frd, 32'hDEADBEEF);
            check("lk_wcnt_hold", 32'(s_wcnt), 32'd2);

    // Partial byte-enable write, then read back.
    l_req = 1; l_we = 1; l_be = 4'b0011; l_wdata = 32'h0000AAAA; l_addr = 5'd8;
    step();
    l_we = 0;
    step();
    l_req = 0;
    step(); check("be_lv", 32'(s_lv), 32'd1);
            check("be_rd", s_lrd, 32'hDEADAAAA);
            check("be_fv", 32'(s_fv), 32'd0);

    // Counter saturation in a long locked burst of be=0 writes.
    f_req = 1; f_addr = '0;
    l_req = 1; l_we = 1; l_lock = 1; l_be = 4'h0;
    for (int k = 0; k < 40; k++) begin
      l_addr = AW'($urandom_range(0, DEPTH - 1)); l_wdata = $urandom;
      step();
    end
    l_req = 0; f_req = 0;
    step(); check("sat_wcnt", 32'(s_wcnt), 32'(DEPTH));
    l_lock = 0;
    step(); step(); check("sat_hold", 32'(s_wcnt), 32'(DEPTH));

    // Reset right after a fetch grant drops the response.
    f_req = 1; f_addr = 5'd5;
    step();
    f_req = 0; rstn = 0;
    step(); check("mr_fv", 32'(s_fv), 32'd0);
    rstn = 1; f_req = 1; l_req = 1; l_we = 0;
    step(); check("mr_fg", 32'(s_fg), 32'd1);
            check("mr_lock", 32'(s_lock), 32'd0);
    f_req = 0; l_req = 0;
    step();

    // Random traffic honouring hold-until-granted.
    for (int c = 0; c < 3000; c++) begin
      if (!f_req || e_fg) begin
        f_req  = ($urandom_range(0, 9) < 7);
        f_addr = AW'($urandom_range(0, DEPTH - 1));
      end
      if (!l_req || e_lg) begin
        if ($urandom_range(0, 19) == 0) burst = !burst;
        l_req   = ($urandom_range(0, 9) < 6);
        l_we    = 1'($urandom_range(0, 1));
        l_lock  = burst;
        l_addr  = AW'($urandom_range(0, DEPTH - 1));
        l_wdata = $urandom;
        l_be    = 4'($urandom_range(0, 15));
      end
      rstn = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
